// File: rtl/while_loop.sv
// Handshaked while-loop sequencer: repeatedly requests a condition evaluation and, while it holds,
// a body execution; counts completed bodies and optionally stops at an iteration limit.
module while_loop #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned MAX_ITER = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  output logic             condReq,
  input  logic             condFin,
  input  logic             boolIn,
  output logic             bodyReq,
  input  logic             bodyFin,
  output logic             fin,
  output logic             busy,
  output logic [CNT_W-1:0] iterCount,
  output logic             limitHit
);

  typedef enum logic [2:0] {
    StIdle,
    StCond,
    StWaitCond,
    StBody,
    StWaitBody,
    StDone
  } state_e;

  localparam logic [CNT_W-1:0] IterSat   = '1;
  localparam logic [CNT_W-1:0] IterLimit = CNT_W'(MAX_ITER);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] iter_q, iter_d, iter_inc;
  logic             limit_q, limit_d;

  // Saturating increment so an unlimited loop never wraps the count.
  assign iter_inc = (iter_q == IterSat) ? iter_q : iter_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      iter_q  <= '0;
      limit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      limit_q <= limit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    limit_d = limit_q;
    case (state_q)
      StIdle: begin
        if (req) begin
          state_d = StCond;
          iter_d  = '0;
          limit_d = 1'b0;
        end
      end
      StCond:     state_d = StWaitCond;
      StWaitCond: begin
        if (condFin) state_d = boolIn ? StBody : StDone;
      end
      StBody:     state_d = StWaitBody;
      StWaitBody: begin
        if (bodyFin) begin
          iter_d = iter_inc;
          if ((MAX_ITER != 0) && (iter_inc == IterLimit)) begin
            state_d = StDone;
            limit_d = 1'b1;
          end else begin
            state_d = StCond;
          end
        end
      end
      StDone:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    condReq   = (state_q == StCond);
    bodyReq   = (state_q == StBody);
    fin       = (state_q == StDone);
    busy      = (state_q != StIdle);
    iterCount = iter_q;
    limitHit  = limit_q;
  end

endmodule
